// File: rtl/full_adder_dataflow.sv
// Purpose: WIDTH-bit ripple-carry full adder ({Cout,S} = A + B + Cin) built from 1-bit dataflow cells.
// Latency: 1 cycle with OUT_REG=1 (registered S/Cout); 0 cycles with OUT_REG=0 (purely combinational).
// Backpressure: none; a new operand set is accepted every cycle and there is no handshake.

// One-bit dataflow full-adder cell; the ripple chain is a string of these.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;

  // Propagate term is shared by the sum and the carry equations.
  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);

endmodule

module full_adder_dataflow #(
  parameter int WIDTH   = 1,
  parameter bit OUT_REG = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] S,
  output logic             Cout
);

  // Carry chain: c[0] is the carry into bit 0, c[WIDTH] is the carry out of the top bit.
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] sum_w;

  assign c[0] = Cin;

  // Ripple chain of dataflow cells, bit 0 first. X/Z on any operand flows through the
  // gate equations untouched, so unknowns are never masked.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    fa_cell u_cell (
      .a  (A[i]),
      .b  (B[i]),
      .ci (c[i]),
      .s  (sum_w[i]),
      .co (c[i+1])
    );
  end

  if (OUT_REG) begin : g_reg
    logic [WIDTH-1:0] s_d;
    logic [WIDTH-1:0] s_q;
    logic             cout_d;
    logic             cout_q;

    // Next-state is simply the combinational sum; kept separate so the flops stay plain.
    always_comb begin
      s_d    = sum_w;
      cout_d = c[WIDTH];
    end

    // Output register; reset clears immediately and discards whatever sum was in flight.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s_q    <= '0;
        cout_q <= 1'b0;
      end else begin
        s_q    <= s_d;
        cout_q <= cout_d;
      end
    end

    assign S    = s_q;
    assign Cout = cout_q;
  end else begin : g_comb
    // Clock and reset are deliberately unused in the combinational build.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;

    assign S    = sum_w;
    assign Cout = c[WIDTH];
  end

endmodule

// File: tb/tb_full_adder_dataflow.sv
`timescale 1ps/1ps
module tb_full_adder_dataflow;

  logic       clk;
  logic       rst;
  logic       a1, b1, c1;
  logic       s1, co1;
  logic [7:0] a8, b8;
  logic       c8;
  logic [7:0] s8;
  logic       co8;
  logic       a0, b0, c0;
  logic       s0, co0;

  int checks = 0;
  int errors = 0;

  // Hand-computed {Cout,S} for {A,B,Cin} = 000 .. 111.
  logic [1:0] fa_exp [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

  full_adder_dataflow #(.WIDTH(1), .OUT_REG(1'b1)) dut_w1 (
    .clk(clk), .rst(rst), .A(a1), .B(b1), .Cin(c1), .S(s1), .Cout(co1)
  );

  full_adder_dataflow #(.WIDTH(8), .OUT_REG(1'b1)) dut_w8 (
    .clk(clk), .rst(rst), .A(a8), .B(b8), .Cin(c8), .S(s8), .Cout(co8)
  );

  full_adder_dataflow #(.WIDTH(1), .OUT_REG(1'b0)) dut_comb (
    .clk(clk), .rst(rst), .A(a0), .B(b0), .Cin(c0), .S(s0), .Cout(co0)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic test_reset();
    // Assert reset well before the first rising edge (t=50).
    #10;
    rst = 1'b1;
    a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
    a8 = 8'h80; b8 = 8'h80; c8 = 1'b1;
    #10;
    checks++;
    if ({co1, s1} !== 2'b00) begin
      errors++;
      $display("FAIL reset_immediate_w1 got %b expected 00", {co1, s1});
    end
    checks++;
    if ({co8, s8} !== 9'h000) begin
      errors++;
      $display("FAIL reset_immediate_w8 got %h expected 000", {co8, s8});
    end
    // Still held after a rising edge while rst is high.
    @(posedge clk); #10;
    checks++;
    if ({co1, s1} !== 2'b00) begin
      errors++;
      $display("FAIL reset_hold_w1 got %b expected 00", {co1, s1});
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #10;
    checks++;
    if ({co1, s1} !== 2'b11) begin
      errors++;
      $display("FAIL reset_release_w1 got %b expected 11", {co1, s1});
    end
    checks++;
    if ({co8, s8} !== 9'h101) begin
      errors++;
      $display("FAIL reset_release_w8 got %h expected 101", {co8, s8});
    end
  endtask

  task automatic test_exhaustive_w1();
    for (int v = 0; v < 8; v++) begin
      @(negedge clk);
      {a1, b1, c1} = v[2:0];
      @(posedge clk); #10;
      checks++;
      if ({co1, s1} !== fa_exp[v]) begin
        errors++;
        $display("FAIL exhaustive_w1 abc=%b got %b expected %b", v[2:0], {co1, s1}, fa_exp[v]);
      end
    end
  endtask

  task automatic test_latency();
    @(negedge clk);
    a1 = 1'b0; b1 = 1'b1; c1 = 1'b1;
    @(posedge clk); #10;
    checks++;
    if ({co1, s1} !== 2'b10) begin
      errors++;
      $display("FAIL latency_prior got %b expected 10", {co1, s1});
    end
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b0; c1 = 1'b0;
    #10;
    checks++;
    if ({co1, s1} !== 2'b10) begin
      errors++;
      $display("FAIL latency_before_edge got %b expected 10", {co1, s1});
    end
    @(posedge clk); #10;
    checks++;
    if ({co1, s1} !== 2'b01) begin
      errors++;
      $display("FAIL latency_after_edge got %b expected 01", {co1, s1});
    end
  endtask

  task automatic test_async_reset_mid();
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
    a0 = 1'b1; b0 = 1'b1; c0 = 1'b0;
    @(posedge clk); #10;
    checks++;
    if ({co1, s1} !== 2'b11) begin
      errors++;
      $display("FAIL midreset_prior got %b expected 11", {co1, s1});
    end
    // Between edges: rising edge at +0, now +10; assert at +25.
    #15;
    rst = 1'b1;
    #1;
    checks++;
    if ({co1, s1} !== 2'b00) begin
      errors++;
      $display("FAIL midreset_immediate got %b expected 00", {co1, s1});
    end
    checks++;
    if ({co0, s0} !== 2'b10) begin
      errors++;
      $display("FAIL midreset_comb_unaffected got %b expected 10", {co0, s0});
    end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #10;
      checks++;
      if ({co1, s1} !== 2'b00) begin
        errors++;
        $display("FAIL midreset_hold cycle=%0d got %b expected 00", k, {co1, s1});
      end
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #10;
    checks++;
    if ({co1, s1} !== 2'b11) begin
      errors++;
      $display("FAIL midreset_release got %b expected 11", {co1, s1});
    end
  endtask

  task automatic test_width8();
    logic [7:0] va [5] = '{8'hFF, 8'hA5, 8'hFF, 8'h00, 8'h3C};
    logic [7:0] vb [5] = '{8'h00, 8'h5A, 8'hFF, 8'h00, 8'h0F};
    logic       vc [5] = '{1'b1,  1'b0,  1'b1,  1'b0,  1'b1};
    logic [8:0] ve [5] = '{9'h100, 9'h0FF, 9'h1FF, 9'h000, 9'h04C};
    for (int v = 0; v < 5; v++) begin
      @(negedge clk);
      a8 = va[v]; b8 = vb[v]; c8 = vc[v];
      @(posedge clk); #10;
      checks++;
      if ({co8, s8} !== ve[v]) begin
        errors++;
        $display("FAIL width8 a=%h b=%h cin=%b got %h expected %h", va[v], vb[v], vc[v], {co8, s8}, ve[v]);
      end
    end
  endtask

  task automatic test_comb();
    // Vectors change mid-cycle and are checked a few ps later, never waiting for an edge;
    // rst toggles between vectors and must not matter.
    for (int v = 0; v < 8; v++) begin
      @(negedge clk);
      rst = v[0];
      {a0, b0, c0} = v[2:0];
      #5;
      checks++;
      if ({co0, s0} !== fa_exp[v]) begin
        errors++;
        $display("FAIL comb abc=%b rst=%b got %b expected %b", v[2:0], rst, {co0, s0}, fa_exp[v]);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
    a8 = 8'h00; b8 = 8'h00; c8 = 1'b0;
    a0 = 1'b0; b0 = 1'b0; c0 = 1'b0;
    test_reset();
    test_exhaustive_w1();
    test_latency();
    test_async_reset_mid();
    test_width8();
    test_comb();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
